// File: rtl/addsub_arbiter_if.sv
// Bundle for the two request ports, the shared adder/subtractor connection
// and the response channel of addsub_arbiter.
interface addsub_arbiter_if #(
    parameter int W = 4
);
    logic         r0_valid;
    logic         r0_ready;
    logic         r0_sub;
    logic [W-1:0] r0_a;
    logic [W-1:0] r0_b;

    logic         r1_valid;
    logic         r1_ready;
    logic         r1_sub;
    logic [W-1:0] r1_a;
    logic [W-1:0] r1_b;

    logic [W-1:0] unit_a;
    logic [W-1:0] unit_b;
    logic         unit_sub;
    logic [W-1:0] unit_d;
    logic         unit_ovf;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_d;
    logic         rsp_ovf;

    // Arbiter side: takes requests and unit results, drives grants, unit operands, responses.
    modport slave (
        input  r0_valid, r0_sub, r0_a, r0_b,
        input  r1_valid, r1_sub, r1_a, r1_b,
        output r0_ready, r1_ready,
        output unit_a, unit_b, unit_sub,
        input  unit_d, unit_ovf,
        output rsp_valid, rsp_id, rsp_d, rsp_ovf,
        input  rsp_ready
    );

    modport master (
        output r0_valid, r0_sub, r0_a, r0_b,
        output r1_valid, r1_sub, r1_a, r1_b,
        input  r0_ready, r1_ready,
        input  unit_a, unit_b, unit_sub,
        output unit_d, unit_ovf,
        input  rsp_valid, rsp_id, rsp_d, rsp_ovf,
        output rsp_ready
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one combinational adder/subtractor between two
// requesters; each op runs IDLE -> EXEC -> RESP and returns a tagged response.
//
//   state | meaning
//   IDLE  | waiting for a request; ready offered to the round-robin winner
//   EXEC  | op registers drive the shared unit; result captured at the edge
//   RESP  | response held until the consumer takes it
module addsub_arbiter #(
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst,
    addsub_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_q;
    logic         last_q;
    logic         id_q;
    logic         sub_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         rsp_valid_q;
    logic [W-1:0] rsp_d_q;
    logic         rsp_ovf_q;

    logic grant0_d;
    logic grant1_d;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0_d = bus.r0_valid && (!bus.r1_valid || last_q);
        grant1_d = bus.r1_valid && (!bus.r0_valid || !last_q);
    end

    assign bus.r0_ready  = (state_q == IDLE) && grant0_d;
    assign bus.r1_ready  = (state_q == IDLE) && grant1_d;

    assign bus.unit_a    = a_q;
    assign bus.unit_b    = b_q;
    assign bus.unit_sub  = sub_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_d     = rsp_d_q;
    assign bus.rsp_ovf   = rsp_ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            sub_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_d_q     <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0_d) begin
                        sub_q   <= bus.r0_sub;
                        a_q     <= bus.r0_a;
                        b_q     <= bus.r0_b;
                        last_q  <= 1'b0;
                        id_q    <= 1'b0;
                        state_q <= EXEC;
                    end else if (grant1_d) begin
                        sub_q   <= bus.r1_sub;
                        a_q     <= bus.r1_a;
                        b_q     <= bus.r1_b;
                        last_q  <= 1'b1;
                        id_q    <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_d_q     <= bus.unit_d;
                    rsp_ovf_q   <= bus.unit_ovf;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed vector table, corner-case
// sequences, and a randomized run against a transaction-level model.
module tb_addsub_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_arbiter_if #(.W(W)) bus ();
    addsub_arbiter #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Behavioural model of the shared adder/subtractor.
    logic [W:0] add5;
    logic [W:0] sub5;
    assign add5         = {1'b0, bus.unit_a} + {1'b0, bus.unit_b};
    assign sub5         = {1'b0, bus.unit_a} - {1'b0, bus.unit_b};
    assign bus.unit_d   = bus.unit_sub ? sub5[W-1:0] : add5[W-1:0];
    assign bus.unit_ovf = bus.unit_sub ? (bus.unit_a < bus.unit_b) : add5[W];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit id, input bit v, input bit sub,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 1'b0) begin
            bus.r0_valid = v; bus.r0_sub = sub; bus.r0_a = a; bus.r0_b = b;
        end else begin
            bus.r1_valid = v; bus.r1_sub = sub; bus.r1_a = a; bus.r1_b = b;
        end
    endtask

    task automatic idle_inputs();
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0);
        bus.rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit         id;
        bit         sub;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        bit         ovf;
        int         hold;
    } vec_t;

    vec_t vecs[8];

    // Runs one op from an idle arbiter; hold = cycles of rsp_ready low.
    task automatic run_op(input vec_t v);
        int rdy_me;
        int rdy_other;
        drive_req(v.id, 1'b1, v.sub, v.a, v.b);
        drive_req(!v.id, 1'b0, 1'b0, '0, '0);
        bus.rsp_ready = (v.hold == 0);
        #1;
        rdy_me    = v.id ? int'(bus.r1_ready) : int'(bus.r0_ready);
        rdy_other = v.id ? int'(bus.r0_ready) : int'(bus.r1_ready);
        chk("accept_ready", rdy_me, 1);
        chk("accept_other_ready", rdy_other, 0);
        chk("accept_rsp_valid", int'(bus.rsp_valid), 0);
        tick();
        drive_req(v.id, 1'b0, 1'b0, '0, '0);
        #1;
        chk("exec_rsp_valid", int'(bus.rsp_valid), 0);
        chk("exec_unit_a", int'(bus.unit_a), int'(v.a));
        chk("exec_unit_b", int'(bus.unit_b), int'(v.b));
        chk("exec_unit_sub", int'(bus.unit_sub), int'(v.sub));
        chk("exec_ready", int'(bus.r0_ready | bus.r1_ready), 0);
        tick();
        chk("resp_valid", int'(bus.rsp_valid), 1);
        chk("resp_id", int'(bus.rsp_id), int'(v.id));
        chk("resp_d", int'(bus.rsp_d), int'(v.d));
        chk("resp_ovf", int'(bus.rsp_ovf), int'(v.ovf));
        for (int i = 0; i < v.hold; i++) begin
            tick();
            drive_req(1'b0, 1'b1, 1'b1, 4'h5, 4'h6);
            drive_req(1'b1, 1'b1, 1'b0, 4'h7, 4'h8);
            #1;
            chk("stall_valid", int'(bus.rsp_valid), 1);
            chk("stall_d", int'(bus.rsp_d), int'(v.d));
            chk("stall_ovf", int'(bus.rsp_ovf), int'(v.ovf));
            chk("stall_id", int'(bus.rsp_id), int'(v.id));
            chk("stall_r0_ready", int'(bus.r0_ready), 0);
            chk("stall_r1_ready", int'(bus.r1_ready), 0);
        end
        if (v.hold > 0) begin
            drive_req(1'b0, 1'b0, 1'b0, '0, '0);
            drive_req(1'b1, 1'b0, 1'b0, '0, '0);
            bus.rsp_ready = 1'b1;
        end
        tick();
        chk("back_idle_rsp_valid", int'(bus.rsp_valid), 0);
    endtask

    typedef struct {
        bit         id;
        logic [3:0] d;
        bit         ovf;
    } rsp_t;

    initial begin
        int   grants[$];
        int   ids[$];
        rsp_t expq[$];
        bit   pend[2];
        bit   psub[2];
        int   pa[2];
        int   pb[2];
        bit   acc[2];
        bit   last_m;
        bit   idle_m;
        bit   rsp_hs;
        bit   prev_stall;
        int   age;
        int   e0, e1, ev;
        int   pd, povf, pid;
        rsp_t r;

        vecs[0] = '{id:1'b0, sub:1'b0, a:4'h3, b:4'h4, d:4'h7, ovf:1'b0, hold:0};
        vecs[1] = '{id:1'b1, sub:1'b1, a:4'h3, b:4'h5, d:4'hE, ovf:1'b1, hold:0};
        vecs[2] = '{id:1'b0, sub:1'b0, a:4'hF, b:4'h1, d:4'h0, ovf:1'b1, hold:5};
        vecs[3] = '{id:1'b1, sub:1'b0, a:4'h9, b:4'h8, d:4'h1, ovf:1'b1, hold:0};
        vecs[4] = '{id:1'b0, sub:1'b1, a:4'h5, b:4'h5, d:4'h0, ovf:1'b0, hold:2};
        vecs[5] = '{id:1'b1, sub:1'b1, a:4'h0, b:4'h1, d:4'hF, ovf:1'b1, hold:0};
        vecs[6] = '{id:1'b0, sub:1'b1, a:4'hA, b:4'h3, d:4'h7, ovf:1'b0, hold:0};
        vecs[7] = '{id:1'b1, sub:1'b0, a:4'h6, b:4'h6, d:4'hC, ovf:1'b0, hold:1};

        do_reset();
        chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
        chk("reset_rsp_d", int'(bus.rsp_d), 0);
        chk("reset_rsp_id", int'(bus.rsp_id), 0);
        chk("reset_unit_a", int'(bus.unit_a), 0);

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Continuous contention: strict alternation starting with r0.
        do_reset();
        drive_req(1'b0, 1'b1, 1'b0, 4'h1, 4'h2);
        drive_req(1'b1, 1'b1, 1'b1, 4'h7, 4'h3);
        bus.rsp_ready = 1'b1;
        #1;
        for (int c = 0; c < 13; c++) begin
            chk("never_both_ready", int'(bus.r0_ready & bus.r1_ready), 0);
            if (bus.r0_ready) grants.push_back(0);
            if (bus.r1_ready) grants.push_back(1);
            if (bus.rsp_valid) begin
                ids.push_back(int'(bus.rsp_id));
                chk("contend_d", int'(bus.rsp_d), bus.rsp_id ? 4 : 3);
            end
            tick();
        end
        chk("contend_grant_count", (grants.size() >= 4) ? 1 : 0, 1);
        chk("contend_rsp_count", (ids.size() >= 4) ? 1 : 0, 1);
        for (int k = 0; k < 4 && k < grants.size(); k++) chk("contend_grant_seq", grants[k], k % 2);
        for (int k = 0; k < 4 && k < ids.size(); k++) chk("contend_rsp_id_seq", ids[k], k % 2);
        idle_inputs();
        repeat (4) tick();

        // Reset asserted while r0's op is in EXEC.
        do_reset();
        drive_req(1'b0, 1'b1, 1'b0, 4'h2, 4'h2);
        #1;
        chk("rst_case_accept", int'(bus.r0_ready), 1);
        tick();
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        chk("rst_case_in_exec_unit_a", int'(bus.unit_a), 2);
        rst = 1'b1;
        #1;
        chk("rst_mid_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_mid_rsp_d", int'(bus.rsp_d), 0);
        chk("rst_mid_rsp_ovf", int'(bus.rsp_ovf), 0);
        chk("rst_mid_unit_a", int'(bus.unit_a), 0);
        chk("rst_mid_unit_b", int'(bus.unit_b), 0);
        chk("rst_mid_unit_sub", int'(bus.unit_sub), 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_no_response", int'(bus.rsp_valid), 0);
        end
        drive_req(1'b0, 1'b1, 1'b0, 4'h1, 4'h1);
        drive_req(1'b1, 1'b1, 1'b0, 4'h9, 4'h4);
        #1;
        chk("rst_tie_r0_ready", int'(bus.r0_ready), 1);
        chk("rst_tie_r1_ready", int'(bus.r1_ready), 0);

        // r0 granted and drops valid; r1 waits, then is granted and its operands are captured at accept.
        tick();
        drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        chk("drop_r0_rsp_valid", int'(bus.rsp_valid), 1);
        chk("drop_r0_rsp_id", int'(bus.rsp_id), 0);
        chk("drop_r0_rsp_d", int'(bus.rsp_d), 2);
        chk("drop_r1_wait", int'(bus.r1_ready), 0);
        tick();
        chk("drop_r1_ready", int'(bus.r1_ready), 1);
        tick();
        drive_req(1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
        #1;
        chk("drop_r1_unit_a", int'(bus.unit_a), 9);
        chk("drop_r1_unit_b", int'(bus.unit_b), 4);
        tick();
        chk("drop_r1_rsp_id", int'(bus.rsp_id), 1);
        chk("drop_r1_rsp_d", int'(bus.rsp_d), 13);
        chk("drop_r1_rsp_ovf", int'(bus.rsp_ovf), 0);
        tick();

        // Randomized traffic against a transaction-level model.
        do_reset();
        last_m = 1'b1; idle_m = 1'b1; age = 0; rsp_hs = 1'b0; prev_stall = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0; acc[0] = 1'b0; acc[1] = 1'b0;
        pd = 0; povf = 0; pid = 0;
        for (int c = 0; c < 2000; c++) begin
            if (age > 0) age++;
            for (int n = 0; n < 2; n++) begin
                if (acc[n]) begin
                    pend[n] = 1'b0;
                    r.id = n[0];
                    if (psub[n]) begin
                        r.d   = 4'((pa[n] - pb[n] + 16) % 16);
                        r.ovf = (pa[n] < pb[n]);
                    end else begin
                        r.d   = 4'((pa[n] + pb[n]) % 16);
                        r.ovf = ((pa[n] + pb[n]) > 15);
                    end
                    expq.push_back(r);
                    last_m = n[0];
                    idle_m = 1'b0;
                    age    = 1;
                end
            end
            if (rsp_hs) begin
                idle_m = 1'b1;
                age    = 0;
            end
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && ($urandom_range(0, 1) == 1)) begin
                    pend[n] = 1'b1;
                    psub[n] = 1'($urandom_range(0, 1));
                    pa[n]   = int'($urandom_range(0, 15));
                    pb[n]   = int'($urandom_range(0, 15));
                end
                drive_req(n[0], pend[n], psub[n], 4'(pa[n]), 4'(pb[n]));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            e0 = 0; e1 = 0;
            if (idle_m) begin
                if (pend[0] && pend[1]) begin
                    e0 = last_m ? 1 : 0;
                    e1 = last_m ? 0 : 1;
                end else begin
                    e0 = int'(pend[0]);
                    e1 = int'(pend[1]);
                end
            end
            chk("rand_r0_ready", int'(bus.r0_ready), e0);
            chk("rand_r1_ready", int'(bus.r1_ready), e1);
            ev = (age >= 2) ? 1 : 0;
            chk("rand_rsp_valid", int'(bus.rsp_valid), ev);
            if (bus.rsp_valid) begin
                if (expq.size() == 0) begin
                    chk("rand_unexpected_rsp", 1, 0);
                end else begin
                    chk("rand_rsp_id", int'(bus.rsp_id), int'(expq[0].id));
                    chk("rand_rsp_d", int'(bus.rsp_d), int'(expq[0].d));
                    chk("rand_rsp_ovf", int'(bus.rsp_ovf), int'(expq[0].ovf));
                end
            end
            if (prev_stall) begin
                chk("rand_stall_d", int'(bus.rsp_d), pd);
                chk("rand_stall_ovf", int'(bus.rsp_ovf), povf);
                chk("rand_stall_id", int'(bus.rsp_id), pid);
            end
            acc[0] = bus.r0_ready && bus.r0_valid;
            acc[1] = bus.r1_ready && bus.r1_valid;
            rsp_hs = bus.rsp_valid && bus.rsp_ready;
            if (rsp_hs && expq.size() > 0) void'(expq.pop_front());
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            pd   = int'(bus.rsp_d);
            povf = int'(bus.rsp_ovf);
            pid  = int'(bus.rsp_id);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
